decodificador_bcd_barrido: RTL and testbench



---
 rtl/decodificador_bcd_barrido_if.sv | 23 ++
 rtl/decodificador_bcd_barrido.sv | 156 +++++++++++++++
 tb/tb_decodificador_bcd_barrido.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decodificador_bcd_barrido_if.sv
// Handshake and display bus of the BCD scan decoder: a BCD source (master) feeds
// digits with valid/ready; the decoder (slave) drives the multiplexed display lines.
interface decodificador_bcd_barrido_if #(
  parameter int DIGITS = 4
);
  logic [3:0]        bcd_in;
  logic              bcd_valid;
  logic              bcd_ready;
  logic [9:0]        dec;
  logic [DIGITS-1:0] dig_sel;
  logic              frame_done;
  logic              err;

  modport master (
    output bcd_in, bcd_valid,
    input  bcd_ready, dec, dig_sel, frame_done, err
  );

  modport slave (
    input  bcd_in, bcd_valid,
    output bcd_ready, dec, dig_sel, frame_done, err
  );
endinterface

// File: rtl/decodificador_bcd_barrido.sv
// Loads a frame of DIGITS BCD codes, then replays it as one-hot decimal lines, one digit per
// SCAN_DIV-cycle slot. Define DECOD_ERR_EN to build the sticky invalid-code flag on err.
module decodificador_bcd_barrido #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input logic                        clk,
  input logic                        reset,
  decodificador_bcd_barrido_if.slave bus
);
  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SCAN_DIV - 1);

  typedef enum logic {CARGA, BARRIDO} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     wr_idx, wr_idx_n;
  logic [IW-1:0]     scan_idx, scan_idx_n;
  logic [CW-1:0]     slot_cnt, slot_cnt_n;
  logic [3:0]        buffer [DIGITS];
  logic              buf_we;
  logic              bcd_ready, bcd_ready_n;
  logic [9:0]        dec, dec_n;
  logic [DIGITS-1:0] dig_sel, dig_sel_n;
  logic              frame_done, frame_done_n;
  logic              show;
  logic [IW-1:0]     show_idx;
  logic [3:0]        show_code;

  // Codes 10..15 light no line; 15 is the encoder's legitimate blank code.
  function automatic logic [9:0] decode(input logic [3:0] code);
    logic [9:0] lines;
    lines = '0;
    if (code <= 4'd9) lines[code] = 1'b1;
    return lines;
  endfunction

  assign show_code = buffer[show_idx];

  // Next-state logic; "show" marks the edge that puts a new digit on the display.
  always_comb begin
    state_n      = state;
    wr_idx_n     = wr_idx;
    scan_idx_n   = scan_idx;
    slot_cnt_n   = slot_cnt;
    bcd_ready_n  = bcd_ready;
    dec_n        = dec;
    dig_sel_n    = dig_sel;
    frame_done_n = 1'b0;
    buf_we       = 1'b0;
    show         = 1'b0;
    show_idx     = '0;
    case (state)
      CARGA: begin
        if (bus.bcd_valid && bcd_ready) begin
          buf_we = 1'b1;
          if (wr_idx == LAST_IDX) begin
            wr_idx_n    = '0;
            state_n     = BARRIDO;
            bcd_ready_n = 1'b0;
            scan_idx_n  = '0;
            slot_cnt_n  = '0;
            show        = 1'b1;
          end else begin
            wr_idx_n = wr_idx + 1'b1;
          end
        end
      end
      BARRIDO: begin
        if (slot_cnt == LAST_SLOT) begin
          slot_cnt_n = '0;
          if (scan_idx == LAST_IDX) begin
            state_n      = CARGA;
            bcd_ready_n  = 1'b1;
            dec_n        = '0;
            dig_sel_n    = '0;
            frame_done_n = 1'b1;
            scan_idx_n   = '0;
          end else begin
            scan_idx_n = scan_idx + 1'b1;
            show       = 1'b1;
            show_idx   = scan_idx + 1'b1;
          end
        end else begin
          slot_cnt_n = slot_cnt + 1'b1;
        end
      end
      default: begin
        state_n = CARGA;
      end
    endcase
    if (show) begin
      dec_n     = decode(show_code);
      dig_sel_n = DIGITS'(1) << show_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CARGA;
      wr_idx     <= '0;
      scan_idx   <= '0;
      slot_cnt   <= '0;
      bcd_ready  <= 1'b1;
      dec        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      wr_idx     <= wr_idx_n;
      scan_idx   <= scan_idx_n;
      slot_cnt   <= slot_cnt_n;
      bcd_ready  <= bcd_ready_n;
      dec        <= dec_n;
      dig_sel    <= dig_sel_n;
      frame_done <= frame_done_n;
    end
  end

  // Frame storage needs no reset: every slot is rewritten before it is scanned.
  always_ff @(posedge clk) begin
    if (buf_we) buffer[wr_idx] <= bus.bcd_in;
  end

  assign bus.bcd_ready  = bcd_ready;
  assign bus.dec        = dec;
  assign bus.dig_sel    = dig_sel;
  assign bus.frame_done = frame_done;

`ifdef DECOD_ERR_EN
  logic err, err_n;

  // Codes are checked only when shown, so a bad code flags once per presentation edge.
  always_comb begin
    err_n = err;
    if (show && (show_code >= 4'd10) && (show_code != 4'hF)) err_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= err_n;
  end

  assign bus.err = err;
`else
  assign bus.err = 1'b0;
`endif

  a_dec_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(dec));
  a_sel_scan    : assert property (@(posedge clk) disable iff (reset)
                                   (state == BARRIDO) |-> $onehot(dig_sel));
  a_sel_load    : assert property (@(posedge clk) disable iff (reset)
                                   (state == CARGA) |-> (dig_sel == '0));
endmodule

// File: tb/tb_decodificador_bcd_barrido.sv
// Drives two decoders (SCAN_DIV=4 and SCAN_DIV=1) with directed and random BCD traffic
// and compares every output, every cycle, against a frame/slot arithmetic model.
module tb_decodificador_bcd_barrido;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tb_bcd;
  logic       tb_valid;
  int         passCount = 0;
  int         totalCount = 0;

`ifdef DECOD_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  decodificador_bcd_barrido_if #(.DIGITS(4)) bus4 ();
  decodificador_bcd_barrido_if #(.DIGITS(4)) bus1 ();

  assign bus4.bcd_in    = tb_bcd;
  assign bus4.bcd_valid = tb_valid;
  assign bus1.bcd_in    = tb_bcd;
  assign bus1.bcd_valid = tb_valid;

  decodificador_bcd_barrido #(.DIGITS(4), .SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  decodificador_bcd_barrido #(.DIGITS(4), .SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Reference model, index 0 -> SCAN_DIV=4 instance, index 1 -> SCAN_DIV=1 instance.
  bit          scanning [2];
  int unsigned nsince [2];
  int          nld [2];
  logic [3:0]  ld [2][4];
  logic [3:0]  fr [2][4];
  logic [9:0]  e_dec [2];
  logic [3:0]  e_sel [2];
  logic        e_rdy [2];
  logic        e_fd [2];
  logic        e_err [2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic checkAll();
    checkOutput("s4 dec",        bus4.dec,        e_dec[0]);
    checkOutput("s4 dig_sel",    bus4.dig_sel,    e_sel[0]);
    checkOutput("s4 bcd_ready",  bus4.bcd_ready,  e_rdy[0]);
    checkOutput("s4 frame_done", bus4.frame_done, e_fd[0]);
    checkOutput("s4 err",        bus4.err,        e_err[0]);
    checkOutput("s1 dec",        bus1.dec,        e_dec[1]);
    checkOutput("s1 dig_sel",    bus1.dig_sel,    e_sel[1]);
    checkOutput("s1 bcd_ready",  bus1.bcd_ready,  e_rdy[1]);
    checkOutput("s1 frame_done", bus1.frame_done, e_fd[1]);
    checkOutput("s1 err",        bus1.err,        e_err[1]);
  endtask

  task automatic modelReset();
    for (int g = 0; g < 2; g++) begin
      scanning[g] = 1'b0;
      nsince[g]   = 0;
      nld[g]      = 0;
      e_dec[g]    = '0;
      e_sel[g]    = '0;
      e_rdy[g]    = 1'b1;
      e_fd[g]     = 1'b0;
      e_err[g]    = 1'b0;
    end
  endtask

  // Predicts the outputs after the next rising edge given the inputs held across it.
  task automatic modelStep(input logic v, input logic [3:0] d);
    int unsigned k;
    int unsigned s;
    for (int g = 0; g < 2; g++) begin
      s = (g == 0) ? 4 : 1;
      e_fd[g] = 1'b0;
      if (!scanning[g] && v && e_rdy[g]) begin
        ld[g][nld[g]] = d;
        nld[g]++;
        if (nld[g] == 4) begin
          for (int j = 0; j < 4; j++) fr[g][j] = ld[g][j];
          nld[g]      = 0;
          scanning[g] = 1'b1;
          nsince[g]   = 0;
          e_rdy[g]    = 1'b0;
        end
      end
      if (scanning[g]) begin
        nsince[g]++;
        if (nsince[g] == 4 * s + 1) begin
          scanning[g] = 1'b0;
          e_rdy[g]    = 1'b1;
          e_fd[g]     = 1'b1;
          e_sel[g]    = '0;
          e_dec[g]    = '0;
        end else begin
          k        = (nsince[g] - 1) / s;
          e_sel[g] = 4'(1 << k);
          e_dec[g] = (fr[g][k] <= 4'd9) ? 10'(1 << fr[g][k]) : 10'd0;
`ifdef DECOD_ERR_EN
          if (((nsince[g] - 1) % s == 0) && (fr[g][k] >= 4'd10) && (fr[g][k] != 4'd15))
            e_err[g] = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d);
    @(negedge clk);
    checkAll();
    tb_valid = v;
    tb_bcd   = d;
    modelStep(v, d);
  endtask

  task automatic applyReset();
    @(negedge clk);
    checkAll();
    tb_valid = 1'b0;
    reset    = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    checkAll();
    reset = 1'b0;
    modelStep(1'b0, tb_bcd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0);
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    tb_valid = 1'b0;
    tb_bcd   = 4'd0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b0;
    modelStep(1'b0, 4'd0);

    $display("[TB] frame 3,7,0,9 with valid held");
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd9);
    cnt = 0;
    for (int i = 1; i <= 40 && cnt == 0; i++) begin
      applyStimulus(i < 16, 4'd5);
      if (bus4.frame_done === 1'b1) cnt = i;
    end
    checkOutput("s4 fd_latency", cnt, 17);
    applyReset();

    $display("[TB] frame with blank code");
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd4);
    idle(20);

    $display("[TB] frame with invalid code, then a clean frame");
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'hC);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd0);
    idle(20);
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd3);
    idle(20);
    checkOutput("s4 err_sticky", bus4.err, ERR_EXP);
    applyReset();

    $display("[TB] gapped valid, then valid during scan");
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b0, 4'd9);
    applyStimulus(1'b0, 4'd9);
    applyStimulus(1'b1, 4'd4);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b0, 4'd9);
    applyStimulus(1'b1, 4'd8);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)));
    idle(20);
    applyReset();

    $display("[TB] reset mid-load and mid-scan");
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd6);
    applyReset();
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd4);
    idle(9);
    applyReset();
    applyStimulus(1'b1, 4'd8);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b1, 4'd9);
    idle(20);
    applyReset();

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 4'd9);
    applyStimulus(1'b1, 4'd8);
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd6);
    idle(4);
    @(negedge clk);
    checkAll();
    checkOutput("s1 fd_b2b", bus1.frame_done, 1'b1);
    checkOutput("s1 rdy_b2b", bus1.bcd_ready, 1'b1);
    tb_valid = 1'b1;
    tb_bcd   = 4'd0;
    modelStep(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd3);
    idle(20);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) applyReset();
      else applyStimulus($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
    end
    idle(20);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
